// File: rtl/reg_read_stage.sv
// Register-read stage sitting in front of the 3R/1W register file.
// It drives the file's read selects and tracks a pending-write scoreboard
// so that RAW/WAW hazards stall at the input. Operands come straight from
// the file's synchronous read ports, so no data is stored in this block.
//
// state | meaning
// EMPTY | no instruction held, out_valid low
// FULL  | instruction held, operands on out_data_*, out_valid high
module reg_read_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGS      = 16,
    parameter int SEL_WIDTH     = 4,
    parameter int PAYLOAD_WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_WIDTH-1:0]     in_sel_ra,
    input  logic [SEL_WIDTH-1:0]     in_sel_rb,
    input  logic [SEL_WIDTH-1:0]     in_sel_rc,
    input  logic [2:0]               in_uses,
    input  logic [SEL_WIDTH-1:0]     in_dest_sel,
    input  logic                     in_dest_write,
    input  logic [PAYLOAD_WIDTH-1:0] in_payload,
    output logic [SEL_WIDTH-1:0]     rf_read_sel_ra,
    output logic [SEL_WIDTH-1:0]     rf_read_sel_rb,
    output logic [SEL_WIDTH-1:0]     rf_read_sel_rc,
    input  logic [DATA_WIDTH-1:0]    rf_read_data_ra,
    input  logic [DATA_WIDTH-1:0]    rf_read_data_rb,
    input  logic [DATA_WIDTH-1:0]    rf_read_data_rc,
    input  logic                     wb_write_en,
    input  logic [SEL_WIDTH-1:0]     wb_write_sel,
    input  logic                     flush,
    input  logic [NUM_REGS-1:0]      flush_clear_mask,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data_ra,
    output logic [DATA_WIDTH-1:0]    out_data_rb,
    output logic [DATA_WIDTH-1:0]    out_data_rc,
    output logic [SEL_WIDTH-1:0]     out_dest_sel,
    output logic                     out_dest_write,
    output logic [PAYLOAD_WIDTH-1:0] out_payload
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                   state, state_nxt;
    logic [NUM_REGS-1:0]      scoreboard, scoreboard_nxt;
    logic [NUM_REGS-1:0]      pending;
    logic                     hazard;
    logic                     accept;

    logic [SEL_WIDTH-1:0]     hold_sel_ra, hold_sel_rb, hold_sel_rc;
    logic [2:0]               hold_uses;
    logic [SEL_WIDTH-1:0]     hold_dest_sel;
    logic                     hold_dest_write;
    logic [PAYLOAD_WIDTH-1:0] hold_payload;

    // Effective pending view: r0 never pending, and a register being written
    // back this cycle is forwarded by the file, so it is not a hazard.
    always_comb begin
        pending    = scoreboard;
        pending[0] = 1'b0;
        if (wb_write_en) pending[wb_write_sel] = 1'b0;
    end

    // Hazard detection and input handshake; nothing is accepted in reset.
    always_comb begin
        hazard = in_valid && ((in_uses[0] && pending[in_sel_ra]) ||
                              (in_uses[1] && pending[in_sel_rb]) ||
                              (in_uses[2] && pending[in_sel_rc]) ||
                              (in_dest_write && pending[in_dest_sel]));
        in_ready = rst_n && !flush && !hazard && ((state == EMPTY) || out_ready);
        accept   = in_valid && in_ready;
    end

    // Next-state logic for the EMPTY/FULL holding register.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (accept) state_nxt = FULL;
            FULL: begin
                if (flush)          state_nxt = EMPTY;
                else if (accept)    state_nxt = FULL;
                else if (out_ready) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Scoreboard update: clears first, then the new writer's set wins.
    always_comb begin
        scoreboard_nxt = scoreboard;
        if (wb_write_en) scoreboard_nxt[wb_write_sel] = 1'b0;
        if (flush) begin
            scoreboard_nxt = scoreboard_nxt & ~flush_clear_mask;
            if ((state == FULL) && hold_dest_write) scoreboard_nxt[hold_dest_sel] = 1'b0;
        end
        if (accept && in_dest_write && (in_dest_sel != '0)) scoreboard_nxt[in_dest_sel] = 1'b1;
        scoreboard_nxt[0] = 1'b0;
    end

    // State and scoreboard registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            scoreboard <= '0;
        end else begin
            state      <= state_nxt;
            scoreboard <= scoreboard_nxt;
        end
    end

    // Capture the accepted instruction's selects and control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_sel_ra     <= '0;
            hold_sel_rb     <= '0;
            hold_sel_rc     <= '0;
            hold_uses       <= '0;
            hold_dest_sel   <= '0;
            hold_dest_write <= 1'b0;
            hold_payload    <= '0;
        end else if (accept) begin
            hold_sel_ra     <= in_sel_ra;
            hold_sel_rb     <= in_sel_rb;
            hold_sel_rc     <= in_sel_rc;
            hold_uses       <= in_uses;
            hold_dest_sel   <= in_dest_sel;
            hold_dest_write <= in_dest_write;
            hold_payload    <= in_payload;
        end
    end

    // Under backpressure re-read the held registers so operands stay put.
    always_comb begin
        if ((state == FULL) && !out_ready) begin
            rf_read_sel_ra = hold_sel_ra;
            rf_read_sel_rb = hold_sel_rb;
            rf_read_sel_rc = hold_sel_rc;
        end else begin
            rf_read_sel_ra = in_sel_ra;
            rf_read_sel_rb = in_sel_rb;
            rf_read_sel_rc = in_sel_rc;
        end
    end

    // Operands pass straight through from the file; unused sources read zero.
    always_comb begin
        out_valid      = (state == FULL);
        out_data_ra    = hold_uses[0] ? rf_read_data_ra : '0;
        out_data_rb    = hold_uses[1] ? rf_read_data_rb : '0;
        out_data_rc    = hold_uses[2] ? rf_read_data_rc : '0;
        out_dest_sel   = hold_dest_sel;
        out_dest_write = hold_dest_write;
        out_payload    = hold_payload;
    end

endmodule

// File: tb/tb_reg_read_stage.sv
// Randomized bench for reg_read_stage. A behavioural register file sits on
// the read/write ports; a reference model tracks register contents, pending
// writers and the single held instruction, and predicts every output.
module tb_reg_read_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [3:0]  in_sel_ra, in_sel_rb, in_sel_rc;
    logic [2:0]  in_uses;
    logic [3:0]  in_dest_sel;
    logic        in_dest_write;
    logic [23:0] in_payload;
    logic [3:0]  rf_read_sel_ra, rf_read_sel_rb, rf_read_sel_rc;
    logic [31:0] rf_read_data_ra, rf_read_data_rb, rf_read_data_rc;
    logic        wb_write_en;
    logic [3:0]  wb_write_sel;
    logic [31:0] wb_write_data;
    logic        flush;
    logic [15:0] flush_clear_mask;
    logic        out_valid, out_ready;
    logic [31:0] out_data_ra, out_data_rb, out_data_rc;
    logic [3:0]  out_dest_sel;
    logic        out_dest_write;
    logic [23:0] out_payload;

    int n_vec  = 0;
    int n_miss = 0;

    reg_read_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sel_ra(in_sel_ra), .in_sel_rb(in_sel_rb), .in_sel_rc(in_sel_rc),
        .in_uses(in_uses), .in_dest_sel(in_dest_sel), .in_dest_write(in_dest_write),
        .in_payload(in_payload),
        .rf_read_sel_ra(rf_read_sel_ra), .rf_read_sel_rb(rf_read_sel_rb),
        .rf_read_sel_rc(rf_read_sel_rc),
        .rf_read_data_ra(rf_read_data_ra), .rf_read_data_rb(rf_read_data_rb),
        .rf_read_data_rc(rf_read_data_rc),
        .wb_write_en(wb_write_en), .wb_write_sel(wb_write_sel),
        .flush(flush), .flush_clear_mask(flush_clear_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data_ra(out_data_ra), .out_data_rb(out_data_rb), .out_data_rc(out_data_rc),
        .out_dest_sel(out_dest_sel), .out_dest_write(out_dest_write),
        .out_payload(out_payload)
    );

    always #5 clk = ~clk;

    // Behavioural register file: synchronous read with same-cycle write forwarding.
    logic [31:0] rf_mem [16];

    function automatic logic [31:0] rf_read(input logic [3:0] sel);
        if (sel == 4'd0) return 32'd0;
        if (wb_write_en && wb_write_sel == sel) return wb_write_data;
        return rf_mem[sel];
    endfunction

    always @(posedge clk) begin
        rf_read_data_ra <= rf_read(rf_read_sel_ra);
        rf_read_data_rb <= rf_read(rf_read_sel_rb);
        rf_read_data_rc <= rf_read(rf_read_sel_rc);
        if (wb_write_en && wb_write_sel != 4'd0) rf_mem[wb_write_sel] <= wb_write_data;
    end

    // Reference model state.
    logic [31:0] ref_regs [16];
    bit          ref_sb   [16];
    bit          ref_full;
    logic [3:0]  h_sel [3];
    logic [2:0]  h_uses;
    logic [3:0]  h_dest;
    logic        h_dw;
    logic [23:0] h_pay;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit busy(input logic [3:0] r);
        if (r == 4'd0) return 1'b0;
        if (wb_write_en && wb_write_sel == r) return 1'b0;
        return ref_sb[r];
    endfunction

    task automatic model_reset();
        ref_full = 1'b0;
        foreach (ref_sb[r]) ref_sb[r] = 1'b0;
        foreach (h_sel[k]) h_sel[k] = 4'd0;
        h_uses = 3'd0; h_dest = 4'd0; h_dw = 1'b0; h_pay = 24'd0;
    endtask

    task automatic drive_idle();
        in_valid = 0; in_sel_ra = 0; in_sel_rb = 0; in_sel_rc = 0; in_uses = 0;
        in_dest_sel = 0; in_dest_write = 0; in_payload = 0;
        wb_write_en = 0; wb_write_sel = 0; wb_write_data = 0;
        flush = 0; flush_clear_mask = 0; out_ready = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check_val({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check_val({tag, "_dest_sel"}, {28'd0, out_dest_sel}, 32'd0);
        check_val({tag, "_payload"}, {8'd0, out_payload}, 32'd0);
    endtask

    initial begin
        bit          exp_ready, acc;
        logic [3:0]  exp_sel [3];
        logic [3:0]  cur_sel [3];
        logic [3:0]  pend_list [$];
        logic [31:0] exp_d;

        drive_idle();
        model_reset();
        rst_n = 1'b0;
        ref_regs[0] = 32'd0;

        // Load the register file through the writeback port while in reset.
        for (int r = 1; r < 16; r++) begin
            @(negedge clk);
            wb_write_en = 1; wb_write_sel = 4'(r); wb_write_data = $urandom;
            ref_regs[r] = wb_write_data;
            in_valid = 1;
            #1 check_reset_outputs("reset");
        end
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);

            // Occasional asynchronous reset while an instruction is held.
            if (ref_full && $urandom_range(0, 59) == 0) begin
                drive_idle();
                rst_n = 1'b0;
                #1 check_reset_outputs("midreset");
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end

            in_valid      = ($urandom_range(0, 9) < 8);
            in_sel_ra     = 4'($urandom_range(0, 15));
            in_sel_rb     = 4'($urandom_range(0, 15));
            in_sel_rc     = 4'($urandom_range(0, 15));
            in_uses       = 3'($urandom);
            in_dest_sel   = 4'($urandom_range(0, 15));
            in_dest_write = ($urandom_range(0, 9) < 6);
            in_payload    = 24'($urandom);
            out_ready     = ($urandom_range(0, 9) < 6);
            flush         = ($urandom_range(0, 29) == 0);
            flush_clear_mask = 16'($urandom);
            wb_write_data = $urandom;
            wb_write_en   = ($urandom_range(0, 9) < 4);
            pend_list.delete();
            for (int r = 1; r < 16; r++) if (ref_sb[r]) pend_list.push_back(4'(r));
            if (pend_list.size() != 0 && $urandom_range(0, 9) < 8)
                wb_write_sel = pend_list[$urandom_range(0, pend_list.size() - 1)];
            else
                wb_write_sel = 4'($urandom_range(0, 15));

            cur_sel[0] = in_sel_ra; cur_sel[1] = in_sel_rb; cur_sel[2] = in_sel_rc;
            exp_ready = !flush && (!ref_full || out_ready);
            if (in_valid) begin
                for (int k = 0; k < 3; k++)
                    if (in_uses[k] && busy(cur_sel[k])) exp_ready = 1'b0;
                if (in_dest_write && busy(in_dest_sel)) exp_ready = 1'b0;
            end
            acc = in_valid && exp_ready;
            for (int k = 0; k < 3; k++)
                exp_sel[k] = (ref_full && !out_ready) ? h_sel[k] : cur_sel[k];

            #1;
            check_val("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
            check_val("rd_sel_ra", {28'd0, rf_read_sel_ra}, {28'd0, exp_sel[0]});
            check_val("rd_sel_rb", {28'd0, rf_read_sel_rb}, {28'd0, exp_sel[1]});
            check_val("rd_sel_rc", {28'd0, rf_read_sel_rc}, {28'd0, exp_sel[2]});

            @(posedge clk);
            // Update reference: registers, pending writers, held instruction.
            if (wb_write_en) begin
                ref_sb[wb_write_sel] = 1'b0;
                if (wb_write_sel != 4'd0) ref_regs[wb_write_sel] = wb_write_data;
            end
            if (flush) begin
                for (int r = 0; r < 16; r++) if (flush_clear_mask[r]) ref_sb[r] = 1'b0;
                if (ref_full && h_dw) ref_sb[h_dest] = 1'b0;
            end
            if (acc && in_dest_write && in_dest_sel != 4'd0) ref_sb[in_dest_sel] = 1'b1;
            if (acc) begin
                h_sel = cur_sel; h_uses = in_uses; h_dest = in_dest_sel;
                h_dw = in_dest_write; h_pay = in_payload;
            end
            if (flush)                  ref_full = 1'b0;
            else if (acc)               ref_full = 1'b1;
            else if (ref_full && out_ready) ref_full = 1'b0;

            #1;
            check_val("out_valid", {31'd0, out_valid}, {31'd0, ref_full});
            if (ref_full) begin
                exp_d = h_uses[0] ? ref_regs[h_sel[0]] : 32'd0;
                check_val("data_ra", out_data_ra, exp_d);
                exp_d = h_uses[1] ? ref_regs[h_sel[1]] : 32'd0;
                check_val("data_rb", out_data_rb, exp_d);
                exp_d = h_uses[2] ? ref_regs[h_sel[2]] : 32'd0;
                check_val("data_rc", out_data_rc, exp_d);
                check_val("dest_sel", {28'd0, out_dest_sel}, {28'd0, h_dest});
                check_val("dest_write", {31'd0, out_dest_write}, {31'd0, h_dw});
                check_val("payload", {8'd0, out_payload}, {8'd0, h_pay});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
